// File: rtl/fetch_pkg.sv
// Shared constants, state encoding, IF/ID payload and redirect-target helpers
// for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned IDX_W = 26;
    localparam int unsigned OFF_W = 16;

    localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0040_0000;
    localparam logic [XLEN-1:0] DEF_NOP_WORD = 32'h3800_0000;
    localparam logic [XLEN-1:0] DEF_BAD_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc4;
        logic            valid;
    } ifid_t;

    // J-type target: region bits come from the PC+4 of the jump itself.
    function automatic logic [XLEN-1:0] jump_target(input logic [XLEN-1:0] pc4,
                                                    input logic [IDX_W-1:0] idx);
        return {pc4[31:28], idx, 2'b00};
    endfunction

    function automatic logic [XLEN-1:0] branch_target(input logic [XLEN-1:0] pc4,
                                                      input logic [OFF_W-1:0] off);
        logic [XLEN-1:0] sext_off;
        sext_off = {{14{off[OFF_W-1]}}, off, 2'b00};
        return pc4 + sext_off;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory bus: address and active-low read enable out, word back.
interface instruction_fetch_if;
    import fetch_pkg::*;

    logic [XLEN-1:0] mem_addr;
    logic            mem_rd_n;
    logic [XLEN-1:0] mem_data;

    modport master (output mem_addr, output mem_rd_n, input mem_data);
    modport slave  (input mem_addr, input mem_rd_n, output mem_data);

endinterface

// File: rtl/instruction_fetch_if_id.sv
// IF/ID pipeline register with hold and flush-to-NOP; flush wins over hold.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_WORD = DEF_NOP_WORD
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  hold_i,
    input  logic  flush_i,
    input  ifid_t d_i,
    output ifid_t q_o
);

    ifid_t ifid_q;
    ifid_t ifid_d;

    always_comb begin
        ifid_d = ifid_q;
        if (flush_i) begin
            ifid_d = '{instr: NOP_WORD, pc4: '0, valid: 1'b0};
        end else if (!hold_i) begin
            ifid_d = d_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ifid_q <= '{instr: NOP_WORD, pc4: '0, valid: 1'b0};
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign q_o = ifid_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives instruction memory, applies decode redirects
// and stalls, and halts on a fetch from unmapped memory.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
    parameter logic [XLEN-1:0] NOP_WORD = DEF_NOP_WORD,
    parameter logic [XLEN-1:0] BAD_WORD = DEF_BAD_WORD
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall_i,
    input  logic                jump_i,
    input  logic [IDX_W-1:0]    jump_index_i,
    input  logic                branch_i,
    input  logic [OFF_W-1:0]    branch_off_i,
    instruction_fetch_if.master imem,
    output logic [XLEN-1:0]     ifid_instr_o,
    output logic [XLEN-1:0]     ifid_pc4_o,
    output logic                ifid_valid_o,
    output logic                fetch_err_o
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            err_q, err_d;
    logic            rd_n_q, rd_n_d;
    logic            ifid_hold;
    logic            ifid_flush;
    logic [XLEN-1:0] pc_plus4;
    ifid_t           ifid_d;
    ifid_t           ifid_q;

    assign pc_plus4 = pc_q + 32'd4;
    assign ifid_d   = '{instr: imem.mem_data, pc4: pc_plus4, valid: 1'b1};

    // Per-edge priority in RUN: redirect > stall > unmapped fetch > normal.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        err_d      = err_q;
        ifid_hold  = 1'b1;
        ifid_flush = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (jump_i) begin
                    pc_d       = jump_target(ifid_q.pc4, jump_index_i);
                    ifid_flush = 1'b1;
                end else if (branch_i) begin
                    pc_d       = branch_target(ifid_q.pc4, branch_off_i);
                    ifid_flush = 1'b1;
                end else if (stall_i) begin
                    ifid_hold = 1'b1;
                end else if (imem.mem_data == BAD_WORD) begin
                    state_d    = ST_HALT;
                    err_d      = 1'b1;
                    ifid_flush = 1'b1;
                end else begin
                    pc_d      = pc_plus4;
                    ifid_hold = 1'b0;
                end
            end
            ST_HALT: begin
                ifid_flush = 1'b1;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
        rd_n_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            err_q   <= 1'b0;
            rd_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
            rd_n_q  <= rd_n_d;
        end
    end

    if_id_reg #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold_i  (ifid_hold),
        .flush_i (ifid_flush),
        .d_i     (ifid_d),
        .q_o     (ifid_q)
    );

    assign imem.mem_addr = pc_q;
    assign imem.mem_rd_n = rd_n_q;
    assign ifid_instr_o  = ifid_q.instr;
    assign ifid_pc4_o    = ifid_q.pc4;
    assign ifid_valid_o  = ifid_q.valid;
    assign fetch_err_o   = err_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural ROM and a queue of
// expected post-edge outputs.
module tb_instruction_fetch;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] NOP    = 32'h3800_0000;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        jump;
    logic [25:0] jump_idx;
    logic        branch;
    logic [15:0] branch_off;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        fetch_err;

    instruction_fetch_if mif ();

    instruction_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_i      (stall),
        .jump_i       (jump),
        .jump_index_i (jump_idx),
        .branch_i     (branch),
        .branch_off_i (branch_off),
        .imem         (mif.master),
        .ifid_instr_o (ifid_instr),
        .ifid_pc4_o   (ifid_pc4),
        .ifid_valid_o (ifid_valid),
        .fetch_err_o  (fetch_err)
    );

    // ROM: a J-type word at 0x00400070, unmapped at 0x00400088.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0040_0070) return 32'h0810_0021;
        if (a == 32'h0040_0088) return 32'hFFFF_FFFF;
        return {8'h24, a[23:0]};
    endfunction

    assign mif.mem_data = mem_word(mif.mem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        rd_n;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        err;
        logic        chk_pc4;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Queue the expectation, take one edge, then pop and compare.
    task automatic step(input string tag, input logic [31:0] a, input logic rn,
                        input logic [31:0] ins, input logic [31:0] p4,
                        input logic v, input logic e, input logic cp4);
        exp_t x;
        x = '{a, rn, ins, p4, v, e, cp4};
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check({tag, ".addr"},  mif.mem_addr,         x.addr);
        check({tag, ".rd_n"},  32'(mif.mem_rd_n),    32'(x.rd_n));
        check({tag, ".instr"}, ifid_instr,           x.instr);
        check({tag, ".valid"}, 32'(ifid_valid),      32'(x.valid));
        check({tag, ".err"},   32'(fetch_err),       32'(x.err));
        if (x.chk_pc4) check({tag, ".pc4"}, ifid_pc4, x.pc4);
    endtask

    task automatic run_normal(input int n);
        logic [31:0] fpc;
        for (int i = 0; i < n; i++) begin
            fpc    = exp_pc;
            exp_pc = exp_pc + 32'd4;
            step("run", exp_pc, 1'b0, mem_word(fpc), fpc + 32'd4, 1'b1, 1'b0, 1'b1);
        end
    endtask

    task automatic flush_step(input string tag, input logic [31:0] target);
        step(tag, target, 1'b0, NOP, 32'd0, 1'b0, 1'b0, 1'b0);
        exp_pc = target;
    endtask

    initial begin
        rst_n      = 1'b0;
        stall      = 1'b0;
        jump       = 1'b0;
        jump_idx   = '0;
        branch     = 1'b0;
        branch_off = '0;
        exp_pc     = RST_PC;

        step("rst0", RST_PC, 1'b1, NOP, 32'd0, 1'b0, 1'b0, 1'b1);
        step("rst1", RST_PC, 1'b1, NOP, 32'd0, 1'b0, 1'b0, 1'b1);

        rst_n = 1'b1;
        check("boot.rd_n_pre", 32'(mif.mem_rd_n), 32'd1);
        step("boot", RST_PC, 1'b0, NOP, 32'd0, 1'b0, 1'b0, 1'b1);
        run_normal(4);

        stall = 1'b1;
        repeat (3) step("stall", 32'h0040_0010, 1'b0, mem_word(32'h0040_000C),
                        32'h0040_0010, 1'b1, 1'b0, 1'b1);
        stall = 1'b0;
        run_normal(4);
        check("pre_br.pc4", ifid_pc4, 32'h0040_0020);

        branch     = 1'b1;
        branch_off = 16'hFFFE;
        flush_step("branch", 32'h0040_0018);
        branch = 1'b0;
        run_normal(23);
        check("pre_j.instr", ifid_instr, 32'h0810_0021);
        check("pre_j.pc4", ifid_pc4, 32'h0040_0074);

        jump     = 1'b1;
        jump_idx = 26'h010_0021;
        flush_step("jump", 32'h0040_0084);
        jump = 1'b0;
        run_normal(1);

        // PC now sits on the unmapped word; redirect must discard it.
        jump       = 1'b1;
        branch     = 1'b1;
        stall      = 1'b1;
        jump_idx   = 26'h010_0030;
        branch_off = 16'h0004;
        flush_step("jbs", 32'h0040_00C0);
        jump   = 1'b0;
        branch = 1'b0;
        stall  = 1'b0;
        run_normal(1);

        jump     = 1'b1;
        jump_idx = 26'h010_0022;
        flush_step("jump_bad", 32'h0040_0088);
        jump = 1'b0;

        step("halt", 32'h0040_0088, 1'b1, NOP, 32'd0, 1'b0, 1'b1, 1'b1);
        jump   = 1'b1;
        branch = 1'b1;
        stall  = 1'b1;
        repeat (2) step("halt_hold", 32'h0040_0088, 1'b1, NOP, 32'd0, 1'b0, 1'b1, 1'b1);
        jump   = 1'b0;
        branch = 1'b0;
        stall  = 1'b0;

        rst_n = 1'b0;
        step("rst_mid", RST_PC, 1'b1, NOP, 32'd0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        step("reboot", RST_PC, 1'b0, NOP, 32'd0, 1'b0, 1'b0, 1'b1);
        exp_pc = RST_PC;
        run_normal(2);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
